fp_add_scheduler: RTL and testbench
===================================

// Module: fp_add_scheduler
// PURPOSE
//  Shares one fixed-latency dual-path FP adder (A +/- B) among NUM_REQ requesters.
//  Round-robin arbitration; a tag pipeline matches each result to its requester.
//  Credit-based issue into a result FIFO, so no in-flight result is lost under back-pressure.
//  Sits between client datapaths and the adder core instance.
// PARAMETERS
//  NUM_REQ        4   number of requesters (>=2)
//  TAG_W          2   requester-id width, clog2(NUM_REQ)
//  SIZE_WORD      32  operand/result width (sign+exp+fraction)
//  ADDER_LATENCY  3   adder cycles from add_valid_o to add_result_i valid (>=0)
// PORTS
//  clk            in   1                  clock, rising edge
//  rst_n          in   1                  asynchronous reset, active low
//  req_valid      in   NUM_REQ            per-requester operation valid
//  req_a          in   NUM_REQ*SIZE_WORD  operand A, slice i = requester i
//  req_b          in   NUM_REQ*SIZE_WORD  operand B, slice i = requester i
//  req_op         in   NUM_REQ            0 = add, 1 = subtract
//  req_ready      out  NUM_REQ            one-hot grant; handshake = valid & ready
//  add_valid_o    out  1                  operands valid to adder
//  add_a_o        out  SIZE_WORD          registered operand A
//  add_b_o        out  SIZE_WORD          registered operand B
//  add_op_o       out  1                  registered op (eff_op)
//  add_result_i   in   SIZE_WORD          adder result, ADDER_LATENCY after add_valid_o
//  resp_valid     out  1                  result FIFO not empty
//  resp_tag       out  TAG_W              requester id of head result
//  resp_data      out  SIZE_WORD          head result
//  resp_ready     in   1                  consumer pops head when resp_valid & resp_ready
// BEHAVIOUR
//  Reset: req_ready=0, add_valid_o=0, add_a_o/add_b_o/add_op_o=0, resp_valid=0,
//   resp_tag=0, resp_data=0, rr_ptr=0, credits=FIFO_DEPTH.
//   Reset mid-operation discards all in-flight and queued results.
//  Arbitration (comb.): scan from rr_ptr upward, mod NUM_REQ; first i with req_valid[i]
//   wins if credits>0; req_ready is one-hot or zero. No grant when credits==0.
//  Winner i granted: rr_ptr <= (i+1) mod NUM_REQ; otherwise rr_ptr holds.
//   Requesters hold valid/operands until ready.
//  Issue: accept at edge T -> add_valid_o=1 with operands during T+1 (one cycle).
//   add_valid_o=0 on non-issue cycles.
//  Tag pipe: ADDER_LATENCY+1 stages of {valid, tag}. Stage-out valid at T+1+ADDER_LATENCY:
//   write {tag, add_result_i} into the result FIFO.
//  Result FIFO: depth FIFO_DEPTH=ADDER_LATENCY+2, first-word-fall-through.
//   Earliest resp_valid = T+2+ADDER_LATENCY.
//  Credits = free FIFO slots minus in-flight ops.
//   Accept: -1; pop: +1; accept and pop in the same cycle: unchanged.
//   Credits never below 0; the FIFO never overflows; writes are never dropped.
//  Pop and write in the same cycle on a full or empty FIFO are both legal; the count is adjusted accordingly.
//  Results leave in issue order; ordering across requesters is the global issue order.
// CONFIGURATION
//  `FP_SCHED_STATS_EN defined: adds outputs issue_cnt[15:0] and stall_cnt[15:0], reset 0.
//   issue_cnt: +1 per accept. stall_cnt: +1 per cycle with |req_valid && credits==0.
//   Both wrap 16'hFFFF -> 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package fp_sched_pkg: FIFO_DEPTH = ADDER_LATENCY+2, credit-counter width,
//   tag/entry struct {tag, data}.
//  Sub-module fp_sched_result_fifo: sync FWFT FIFO, async active-low reset, count output.
//  Top: arbiter, rr pointer, operand regs, tag shift pipe, credit counter.
// TESTING (behavioural adder model, ADDER_LATENCY=3, NUM_REQ=4)
//  1. Req1 alone, A=3F800000, B=40000000, op=0, resp_ready=1
//     -> req_ready=0010 at T, add_valid_o at T+1, resp_valid with tag=1, data=40400000 at T+5.
//  2. All four valid continuously, resp_ready=1
//     -> grants rotate 0,1,2,3,0...; one accept per cycle; response tags in the same order.
//  3. rr_ptr=2, only req0 and req3 valid
//     -> req3 granted first, then req0.
//  4. resp_ready=0, all valid
//     -> exactly 5 accepts, then req_ready=0; raise resp_ready -> 5 results drain in order
//        and issue resumes; no result lost.
//  5. rst_n low for 1 cycle with 3 ops in flight
//     -> all outputs at reset values; no stale resp_valid after release; credits=5.
//  6. STATS_EN, resp_ready=0 for 10 cycles with req valid
//     -> issue_cnt=5, stall_cnt=5; counters wrap from FFFF to 0.

Source files
------------

// File: rtl/fp_sched_pkg.sv
// Shared sizing helpers for the FP adder scheduler: result FIFO depth and credit-counter width.
package fp_sched_pkg;

    // One slot per op in the tag pipe plus one so a full pipe can still retire
    // while the head result waits for the consumer.
    function automatic int fifo_depth(input int adder_latency);
        return adder_latency + 2;
    endfunction

    // The credit counter must hold every value from 0 up to fifo_depth.
    function automatic int cred_w(input int adder_latency);
        return $clog2(adder_latency + 3);
    endfunction

    function automatic int entry_w(input int tag_w, input int size_word);
        return tag_w + size_word;
    endfunction

endpackage

// File: rtl/fp_sched_result_fifo.sv
// First-word-fall-through result FIFO. The head entry is visible whenever count != 0.
module fp_sched_result_fifo
    import fp_sched_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    // A pop frees the slot in the same cycle, so write-on-full is legal with a pop.
    assign do_rd   = rd_en && (count != '0);
    assign do_wr   = wr_en && ((count != CNTW'(DEPTH)) || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Round-robin, credit-gated scheduler sharing one fixed-latency FP adder among NUM_REQ clients.
// Optional FP_SCHED_STATS_EN adds issue_cnt/stall_cnt counters.
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TAG_W         = 2,
    parameter int SIZE_WORD     = 32,
    parameter int ADDER_LATENCY = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*SIZE_WORD-1:0] req_a,
    input  logic [NUM_REQ*SIZE_WORD-1:0] req_b,
    input  logic [NUM_REQ-1:0]           req_op,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         add_valid_o,
    output logic [SIZE_WORD-1:0]         add_a_o,
    output logic [SIZE_WORD-1:0]         add_b_o,
    output logic                         add_op_o,
    input  logic [SIZE_WORD-1:0]         add_result_i,
    output logic                         resp_valid,
    output logic [TAG_W-1:0]             resp_tag,
    output logic [SIZE_WORD-1:0]         resp_data,
    input  logic                         resp_ready
`ifdef FP_SCHED_STATS_EN
    ,
    output logic [15:0]                  issue_cnt,
    output logic [15:0]                  stall_cnt
`endif
);
    localparam int FIFO_DEPTH = fifo_depth(ADDER_LATENCY);
    localparam int CW         = cred_w(ADDER_LATENCY);
    localparam int EW         = entry_w(TAG_W, SIZE_WORD);
    localparam int LAT        = ADDER_LATENCY;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [SIZE_WORD-1:0] data;
    } entry_t;

    logic [SIZE_WORD-1:0]          a_arr [NUM_REQ];
    logic [SIZE_WORD-1:0]          b_arr [NUM_REQ];
    logic [TAG_W-1:0]              rr_ptr, win;
    logic [NUM_REQ-1:0]            grant;
    logic [CW-1:0]                 credits;
    logic                          live, accept, pop;
    logic [LAT:0]                  vld_pipe;
    logic [LAT:0][TAG_W-1:0]       tag_pipe;
    entry_t                        wr_entry, head;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*SIZE_WORD +: SIZE_WORD];
        assign b_arr[g] = req_b[g*SIZE_WORD +: SIZE_WORD];
    end

    // First valid requester at or after rr_ptr wins; nothing is granted without a credit.
    always_comb begin : arb
        int idx;
        grant = '0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (grant == '0 && req_valid[idx] && live && credits != '0) begin
                grant[idx] = 1'b1;
                win        = TAG_W'(idx);
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign pop       = resp_valid && resp_ready;

    // live holds off grants while reset is asserted, keeping req_ready at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live        <= 1'b0;
            rr_ptr      <= '0;
            credits     <= CW'(FIFO_DEPTH);
            add_valid_o <= 1'b0;
            add_a_o     <= '0;
            add_b_o     <= '0;
            add_op_o    <= 1'b0;
        end else begin
            live        <= 1'b1;
            add_valid_o <= accept;
            if (accept) begin
                rr_ptr   <= (int'(win) == NUM_REQ - 1) ? '0 : win + TAG_W'(1);
                add_a_o  <= a_arr[win];
                add_b_o  <= b_arr[win];
                add_op_o <= req_op[win];
            end
            case ({accept, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Stage LAT lines up with add_result_i for the op issued LAT+1 cycles earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            tag_pipe[0] <= win;
            for (int s = 1; s <= LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign wr_entry.tag  = tag_pipe[LAT];
    assign wr_entry.data = add_result_i;

    fp_sched_result_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_pipe[LAT]),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    assign resp_valid = (fifo_count != '0);
    assign resp_tag   = resp_valid ? head.tag  : '0;
    assign resp_data  = resp_valid ? head.data : '0;

`ifdef FP_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) issue_cnt <= issue_cnt + 16'd1;
            if (|req_valid && credits == '0) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler with a 3-cycle behavioural FP adder.
module tb_fp_add_scheduler;
    logic               clk;
    logic               rst_n;
    logic [3:0]         req_valid;
    logic [3:0][31:0]   opa, opb;
    logic [3:0]         opc;
    logic [3:0]         req_ready;
    logic               add_valid_o, add_op_o;
    logic [31:0]        add_a_o, add_b_o, add_result_i;
    logic               resp_valid, resp_ready;
    logic [1:0]         resp_tag;
    logic [31:0]        resp_data;
`ifdef FP_SCHED_STATS_EN
    logic [15:0]        issue_cnt, stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int pushes = 0;
    int pops = 0;
    logic [33:0] sb [$];
    logic [31:0] add_pipe [3];

    fp_add_scheduler #(.NUM_REQ(4), .TAG_W(2), .SIZE_WORD(32), .ADDER_LATENCY(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_a        (opa),
        .req_b        (opb),
        .req_op       (opc),
        .req_ready    (req_ready),
        .add_valid_o  (add_valid_o),
        .add_a_o      (add_a_o),
        .add_b_o      (add_b_o),
        .add_op_o     (add_op_o),
        .add_result_i (add_result_i),
        .resp_valid   (resp_valid),
        .resp_tag     (resp_tag),
        .resp_data    (resp_data),
`ifdef FP_SCHED_STATS_EN
        .issue_cnt    (issue_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .resp_ready   (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normal-operand FP32 add/sub, truncating; exact for the operands used here.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [31:0] x, y;
        logic [7:0]  e;
        logic [24:0] mx, my, m;
        int          sh;
        x = a;
        y = {b[31] ^ op, b[30:0]};
        if (y[30:0] > x[30:0]) begin
            x = y;
            y = a;
        end
        e  = x[30:23];
        sh = int'(x[30:23]) - int'(y[30:23]);
        mx = {2'b01, x[22:0]};
        my = {2'b01, y[22:0]};
        my = (sh > 24) ? 25'd0 : (my >> sh);
        if (x[31] == y[31]) begin
            m = mx + my;
            if (m[24]) begin
                m = m >> 1;
                e = e + 8'd1;
            end
        end else begin
            m = mx - my;
            if (m == 25'd0) return 32'h0;
            while (!m[23]) begin
                m = m << 1;
                e = e - 8'd1;
            end
        end
        return {x[31], e, m[22:0]};
    endfunction

    always @(posedge clk) begin
        add_pipe[0] <= add_valid_o ? fp_add(add_a_o, add_b_o, add_op_o) : 32'h0;
        add_pipe[1] <= add_pipe[0];
        add_pipe[2] <= add_pipe[1];
    end
    assign add_result_i = add_pipe[2];

    // Scoreboard: expected {tag, result} pushed at each handshake, checked at each pop.
    always @(negedge clk) begin
        logic [33:0] exp_e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back({2'(i), fp_add(opa[i], opb[i], opc[i])});
                    pushes++;
                end
            end
            if (resp_valid && resp_ready) begin
                pops++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_pop: got tag=%0d data=%h, required no response", resp_tag, resp_data);
                end else begin
                    exp_e = sb.pop_front();
                    if ({resp_tag, resp_data} !== exp_e) begin
                        miscompares++;
                        $display("FAIL sb_pop: got tag=%0d data=%h, required tag=%0d data=%h",
                                 resp_tag, resp_data, exp_e[33:32], exp_e[31:0]);
                    end
                end
            end
        end
    end

    task automatic set_ops();
        opa = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        opb = {32'h3F800000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
        opc = 4'b1000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({req_ready, add_valid_o, add_op_o, resp_valid} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy=%b av=%b op=%b rv=%b, required all 0",
                     req_ready, add_valid_o, add_op_o, resp_valid);
        end
        vectors++;
        if ({add_a_o, add_b_o} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_operands: got a=%h b=%h, required 0", add_a_o, add_b_o);
        end
        vectors++;
        if ({resp_tag, resp_data} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_resp: got tag=%0d data=%h, required 0", resp_tag, resp_data);
        end
        step();
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_single();
        step();
        opa[1] = 32'h3F800000;
        opb[1] = 32'h40000000;
        opc[1] = 1'b0;
        req_valid = 4'b0010;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL single_grant: got %b, required 0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        vectors++;
        if ({add_valid_o, add_a_o, add_b_o, add_op_o} !== {1'b1, 32'h3F800000, 32'h40000000, 1'b0}) begin
            miscompares++;
            $display("FAIL single_issue: got v=%b a=%h b=%h op=%b, required v=1 a=3f800000 b=40000000 op=0",
                     add_valid_o, add_a_o, add_b_o, add_op_o);
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 1'b0 || (c == 2 && add_valid_o !== 1'b0)) begin
                miscompares++;
                $display("FAIL single_early T+%0d: got rv=%b av=%b, required 0", c, resp_valid, add_valid_o);
            end
        end
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_tag, resp_data} !== {1'b1, 2'd1, 32'h40400000}) begin
            miscompares++;
            $display("FAIL single_resp T+5: got v=%b tag=%0d data=%h, required v=1 tag=1 data=40400000",
                     resp_valid, resp_tag, resp_data);
        end
        step();
        set_ops();
        repeat (3) step();
    endtask

    task automatic test_rr_skip();
        logic [3:0] g [2];
        int n = 0;
        step();
        req_valid = 4'b1001;
        for (int c = 0; c < 8 && n < 2; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                g[n] = req_ready;
                n++;
            end
        end
        step();
        req_valid = 4'b0000;
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL rr_skip_timeout: got %0d grants, required 2", n);
        end
        vectors++;
        if (g[0] !== 4'b1000) begin
            miscompares++;
            $display("FAIL rr_skip_first: got %b, required 1000", g[0]);
        end
        vectors++;
        if (g[1] !== 4'b0001) begin
            miscompares++;
            $display("FAIL rr_skip_second: got %b, required 0001", g[1]);
        end
        repeat (10) step();
    endtask

    task automatic test_rotate();
        int n = 0;
        logic [3:0] exp_g;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        for (int c = 0; c < 40 && n < 12; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                exp_g = 4'b0001 << (n % 4);
                vectors++;
                if (req_ready !== exp_g) begin
                    miscompares++;
                    $display("FAIL rotate_grant[%0d]: got %b, required %b", n, req_ready, exp_g);
                end
                n++;
            end
        end
        step();
        req_valid = 4'b0000;
        repeat (12) step();
        vectors++;
        if (n != 12 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL rotate_drain: got %0d grants, %0d pending, required 12 grants, 0 pending", n, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bit resumed = 0;
        step();
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0) n++;
        end
        vectors++;
        if (n != 5) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d, required 5", n);
        end
        vectors++;
        if (req_ready !== 4'b0 || resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_stalled: got rdy=%b rv=%b, required rdy=0000 rv=1", req_ready, resp_valid);
        end
        step();
        resp_ready = 1'b1;
        for (int c = 0; c < 20 && !resumed; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0) resumed = 1;
        end
        step();
        req_valid = 4'b0000;
        vectors++;
        if (!resumed) begin
            miscompares++;
            $display("FAIL bp_resume: got no grant within 20 cycles, required a grant");
        end
        repeat (15) step();
        vectors++;
        if (sb.size() != 0 || pushes != pops) begin
            miscompares++;
            $display("FAIL bp_drain: got %0d pending, %0d pushed vs %0d popped, required none lost",
                     sb.size(), pushes, pops);
        end
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        int stale = 0;
        step();
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        for (int c = 0; c < 10 && n < 3; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0) n++;
        end
        step();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req_ready, add_valid_o, resp_valid, resp_tag, resp_data, add_a_o} !== 71'h0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got rdy=%b av=%b rv=%b tag=%0d data=%h a=%h, required all 0",
                     req_ready, add_valid_o, resp_valid, resp_tag, resp_data, add_a_o);
        end
        step();
        req_valid = 4'b0000;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) stale++;
        end
        vectors++;
        if (n != 3 || stale != 0) begin
            miscompares++;
            $display("FAIL midrst_stale: got %0d pre-reset accepts, %0d stale cycles, required 3 and 0", n, stale);
        end
        step();
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0) n++;
        end
        step();
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        vectors++;
        if (n != 5) begin
            miscompares++;
            $display("FAIL midrst_credits: got %0d accepts, required 5", n);
        end
        repeat (12) step();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL midrst_drain: got %0d pending, required 0", sb.size());
        end
    endtask

`ifdef FP_SCHED_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        repeat (10) step();
        req_valid = 4'b0000;
        @(negedge clk);
        vectors++;
        if (issue_cnt !== 16'd5 || stall_cnt !== 16'd5) begin
            miscompares++;
            $display("FAIL stats_counts: got issue=%0d stall=%0d, required 5 and 5", issue_cnt, stall_cnt);
        end
        step();
        req_valid = 4'b1111;
        repeat (65531) step();
        req_valid = 4'b0000;
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 16'd0 || issue_cnt !== 16'd5) begin
            miscompares++;
            $display("FAIL stats_wrap: got issue=%0d stall=%0d, required 5 and 0", issue_cnt, stall_cnt);
        end
        step();
        resp_ready = 1'b1;
        repeat (12) step();
    endtask
`endif

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        set_ops();
        test_reset();
        test_single();
        test_rr_skip();
        test_rotate();
        test_backpressure();
        test_reset_midflight();
`ifdef FP_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
